// File: rtl/demux_pipeline.sv
// Pipelined 1-to-N demultiplexer built as a radix-R tree of registered stages.
// Define DEMUX_PIPELINE_ZERO_EN to zero every unaddressed node data register.
module demux_pipeline #(
    parameter int WIDTH        = 1,
    parameter int OUTPUT_COUNT = 2,
    parameter int LATENCY      = 1,
    parameter int PRINT        = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [$clog2(OUTPUT_COUNT)-1:0] sel,
    input  logic [WIDTH-1:0]                in,
    output logic [OUTPUT_COUNT-1:0]         out_valid,
    output logic [WIDTH*OUTPUT_COUNT-1:0]   out,
    output logic                            err
);

    function automatic int ipow(input int b, input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    function automatic int calc_radix(input int oc, input int lat);
        int r;
        r = 2;
        while (ipow(r, lat) < oc) r = r * 2;
        return r;
    endfunction

    // Nodes needed at stage s: only subtrees that reach a lane below OUTPUT_COUNT.
    function automatic int calc_nodes(input int oc, input int radix, input int lat, input int s);
        int d;
        d = ipow(radix, lat - s);
        return (oc + d - 1) / d;
    endfunction

    function automatic int calc_doff(input int oc, input int radix, input int lat, input int s);
        int sum;
        sum = 0;
        for (int t = 0; t < s; t++) sum = sum + calc_nodes(oc, radix, lat, t);
        return sum;
    endfunction

    function automatic int calc_roff(input int oc, input int radix, input int lat,
                                     input int rb, input int s);
        int sum;
        sum = 0;
        for (int t = 0; t < s; t++) sum = sum + calc_nodes(oc, radix, lat, t) * (lat - t) * rb;
        return sum;
    endfunction

    localparam int SEL_W   = $clog2(OUTPUT_COUNT);
    localparam int RADIX   = calc_radix(OUTPUT_COUNT, LATENCY);
    localparam int RB      = $clog2(RADIX);
    localparam int SEL_PAD = LATENCY * RB;
    localparam int NT      = calc_doff(OUTPUT_COUNT, RADIX, LATENCY, LATENCY + 1);
    localparam int RT      = calc_roff(OUTPUT_COUNT, RADIX, LATENCY, RB, LATENCY + 1);
    localparam int LOFF    = calc_doff(OUTPUT_COUNT, RADIX, LATENCY, LATENCY);

    if (PRINT != 0) begin : g_print
        $info("demux_pipeline: RADIX=%0d SEL_PAD=%0d", RADIX, SEL_PAD);
    end

    // Flattened node state of every stage; stage 0 is the unregistered input node.
    logic [NT*WIDTH-1:0] node_data;
    logic [NT-1:0]       node_valid;
    logic [RT-1:0]       node_rem;

    logic               in_range;
    logic               drop;
    logic [SEL_PAD-1:0] sel_pad;
    logic [LATENCY-1:0] err_sr;

    if (OUTPUT_COUNT == (1 << SEL_W)) begin : g_full_range
        assign in_range = 1'b1;
    end else begin : g_part_range
        assign in_range = (sel < SEL_W'(OUTPUT_COUNT));
    end

    assign sel_pad                = SEL_PAD'(sel);
    assign drop                   = in_valid & ~in_range;
    assign node_data[WIDTH-1:0]   = in;
    assign node_valid[0]          = in_valid & in_range;
    assign node_rem[SEL_PAD-1:0]  = sel_pad;

    for (genvar s = 1; s <= LATENCY; s++) begin : g_stage
        localparam int N   = calc_nodes(OUTPUT_COUNT, RADIX, LATENCY, s);
        localparam int DO  = calc_doff(OUTPUT_COUNT, RADIX, LATENCY, s);
        localparam int PDO = calc_doff(OUTPUT_COUNT, RADIX, LATENCY, s - 1);
        localparam int RO  = calc_roff(OUTPUT_COUNT, RADIX, LATENCY, RB, s);
        localparam int PRO = calc_roff(OUTPUT_COUNT, RADIX, LATENCY, RB, s - 1);
        localparam int W   = (LATENCY - s) * RB;
        localparam int PW  = W + RB;

        for (genvar j = 0; j < N; j++) begin : g_node
            localparam int             P    = j / RADIX;
            localparam logic [RB-1:0]  SLOT = RB'(j % RADIX);

            logic             hit;
            logic             valid_q;
            logic [WIDTH-1:0] data_q;

            // The parent's top unconsumed sel bits pick exactly one child.
            assign hit = node_valid[PDO + P] &&
                         (node_rem[PRO + P*PW + PW - RB +: RB] == SLOT);

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= hit;
                    if (hit) begin
                        data_q <= node_data[(PDO + P)*WIDTH +: WIDTH];
                    end
`ifdef DEMUX_PIPELINE_ZERO_EN
                    else begin
                        data_q <= '0;
                    end
`endif
                end
            end

            assign node_valid[DO + j]               = valid_q;
            assign node_data[(DO + j)*WIDTH +: WIDTH] = data_q;

            if (W > 0) begin : g_rem
                logic [W-1:0] rem_q;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        rem_q <= '0;
                    end else if (hit) begin
                        rem_q <= node_rem[PRO + P*PW +: W];
                    end
                end

                assign node_rem[RO + j*W +: W] = rem_q;
            end
        end
    end

    // Dropped words travel a plain shift register so err lines up with the data latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sr <= '0;
        end else begin
            err_sr <= (err_sr << 1) | LATENCY'(drop);
        end
    end

    assign err       = err_sr[LATENCY-1];
    assign out_valid = node_valid[LOFF +: OUTPUT_COUNT];
    assign out       = node_data[LOFF*WIDTH +: WIDTH*OUTPUT_COUNT];

endmodule

// File: tb/tb_demux_pipeline.sv
// Directed bench for demux_pipeline: three instances cover LATENCY 1, 2 and 4.
module tb_demux_pipeline;

    logic clk = 1'b0;
    logic rst;

    logic        a_valid;
    logic [1:0]  a_sel;
    logic [7:0]  a_in;
    logic [3:0]  a_ov;
    logic [31:0] a_out;
    logic        a_err;

    logic        b_valid;
    logic [2:0]  b_sel;
    logic [7:0]  b_in;
    logic [5:0]  b_ov;
    logic [47:0] b_out;
    logic        b_err;

    logic         c_valid;
    logic [3:0]   c_sel;
    logic [7:0]   c_in;
    logic [15:0]  c_ov;
    logic [127:0] c_out;
    logic         c_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    demux_pipeline #(.WIDTH(8), .OUTPUT_COUNT(4), .LATENCY(1), .PRINT(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .sel(a_sel), .in(a_in),
        .out_valid(a_ov), .out(a_out), .err(a_err)
    );

    demux_pipeline #(.WIDTH(8), .OUTPUT_COUNT(6), .LATENCY(2), .PRINT(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .sel(b_sel), .in(b_in),
        .out_valid(b_ov), .out(b_out), .err(b_err)
    );

    demux_pipeline #(.WIDTH(8), .OUTPUT_COUNT(16), .LATENCY(4), .PRINT(0)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_valid), .sel(c_sel), .in(c_in),
        .out_valid(c_ov), .out(c_out), .err(c_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        a_valid = 1'b0; a_sel = '0; a_in = '0;
        b_valid = 1'b0; b_sel = '0; b_in = '0;
        c_valid = 1'b0; c_sel = '0; c_in = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_valid = 1'b1; a_sel = 2'd1; a_in = 8'hEE;
        b_valid = 1'b1; b_sel = 3'd1; b_in = 8'hEE;
        c_valid = 1'b1; c_sel = 4'd1; c_in = 8'hEE;
        tick();
        tick();
        n_cmp++;
        if ({a_ov, a_err} !== 5'b0 || a_out !== 32'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_a: ov=%b err=%b out=%h, want all zero", a_ov, a_err, a_out);
        end
        n_cmp++;
        if ({b_ov, b_err} !== 7'b0 || b_out !== 48'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_b: ov=%b err=%b out=%h, want all zero", b_ov, b_err, b_out);
        end
        n_cmp++;
        if ({c_ov, c_err} !== 17'b0 || c_out !== 128'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_c: ov=%h err=%b out=%h, want all zero", c_ov, c_err, c_out);
        end
        rst = 1'b0;
        idle_all();
        tick();
        n_cmp++;
        if (a_ov !== 4'b0 || a_out !== 32'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_discard_a: ov=%b out=%h, want 0/0", a_ov, a_out);
        end
        tick();
        tick();
        tick();
    endtask

    task automatic test_single();
        logic [7:0] hold;
        idle_all();
        tick();
        tick();
        a_valid = 1'b1; a_sel = 2'd2; a_in = 8'hA5;
        tick();
        idle_all();
        n_cmp++;
        if (a_ov !== 4'b0100) begin
            n_bad++;
            $display("[TB] FAIL single_valid: got %b, want 0100", a_ov);
        end
        n_cmp++;
        if (a_out[16 +: 8] !== 8'hA5) begin
            n_bad++;
            $display("[TB] FAIL single_data: got %h, want a5", a_out[16 +: 8]);
        end
`ifdef DEMUX_PIPELINE_ZERO_EN
        hold = 8'h00;
`else
        hold = 8'hA5;
`endif
        for (int t = 0; t < 3; t++) begin
            tick();
            n_cmp++;
            if (a_ov !== 4'b0 || a_err !== 1'b0 || a_out[16 +: 8] !== hold) begin
                n_bad++;
                $display("[TB] FAIL single_after t=%0d: ov=%b err=%b lane2=%h, want 0/0/%h",
                         t, a_ov, a_err, a_out[16 +: 8], hold);
            end
        end
    endtask

    task automatic test_same_lane();
        logic [7:0] hold;
`ifdef DEMUX_PIPELINE_ZERO_EN
        hold = 8'h00;
`else
        hold = 8'h03;
`endif
        for (int t = 0; t < 4; t++) begin
            if (t < 3) begin
                a_valid = 1'b1; a_sel = 2'd3; a_in = 8'(t + 1);
            end else begin
                idle_all();
            end
            tick();
            n_cmp++;
            if (t < 3) begin
                if (a_ov !== 4'b1000 || a_out[24 +: 8] !== 8'(t + 1)) begin
                    n_bad++;
                    $display("[TB] FAIL same_lane_a t=%0d: ov=%b lane3=%h, want 1000/%h",
                             t, a_ov, a_out[24 +: 8], 8'(t + 1));
                end
            end else if (a_ov !== 4'b0 || a_out[24 +: 8] !== hold) begin
                n_bad++;
                $display("[TB] FAIL same_lane_a_hold: ov=%b lane3=%h, want 0/%h",
                         a_ov, a_out[24 +: 8], hold);
            end
        end
        idle_all();
        for (int t = 0; t < 8; t++) begin
            if (t < 3) begin
                c_valid = 1'b1; c_sel = 4'd3; c_in = 8'(t + 1);
            end else begin
                c_valid = 1'b0; c_sel = '0; c_in = '0;
            end
            tick();
            n_cmp++;
            if (t >= 3 && t <= 5) begin
                if (c_ov !== 16'h0008 || c_out[24 +: 8] !== 8'(t - 2)) begin
                    n_bad++;
                    $display("[TB] FAIL same_lane_c t=%0d: ov=%h lane3=%h, want 0008/%h",
                             t, c_ov, c_out[24 +: 8], 8'(t - 2));
                end
            end else if (t > 5) begin
                if (c_ov !== 16'h0 || c_out[24 +: 8] !== hold) begin
                    n_bad++;
                    $display("[TB] FAIL same_lane_c_hold t=%0d: ov=%h lane3=%h, want 0/%h",
                             t, c_ov, c_out[24 +: 8], hold);
                end
            end else if (c_ov !== 16'h0) begin
                n_bad++;
                $display("[TB] FAIL same_lane_c_early t=%0d: ov=%h, want 0", t, c_ov);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_ov;
        logic [7:0] exp_d;
        for (int t = 0; t < 8; t++) begin
            if (t < 6) begin
                b_valid = 1'b1; b_sel = 3'(t); b_in = 8'(8'h11 + t);
            end else begin
                b_valid = 1'b0; b_sel = '0; b_in = '0;
            end
            tick();
            exp_ov = (t >= 1 && t <= 6) ? 6'(1 << (t - 1)) : 6'b0;
            n_cmp++;
            if (b_ov !== exp_ov || b_err !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL b2b_valid t=%0d: ov=%b err=%b, want %b/0", t, b_ov, b_err, exp_ov);
            end
            if (t >= 1 && t <= 6) begin
                exp_d = 8'(8'h11 + t - 1);
                n_cmp++;
                if (b_out[(t - 1)*8 +: 8] !== exp_d) begin
                    n_bad++;
                    $display("[TB] FAIL b2b_data lane%0d: got %h, want %h",
                             t - 1, b_out[(t - 1)*8 +: 8], exp_d);
                end
            end
        end
        for (int k = 0; k < 6; k++) begin
`ifdef DEMUX_PIPELINE_ZERO_EN
            exp_d = 8'h00;
`else
            exp_d = 8'(8'h11 + k);
`endif
            n_cmp++;
            if (b_out[k*8 +: 8] !== exp_d) begin
                n_bad++;
                $display("[TB] FAIL b2b_hold lane%0d: got %h, want %h", k, b_out[k*8 +: 8], exp_d);
            end
        end
    endtask

    task automatic test_idle_ignore();
        logic [7:0] hold;
`ifdef DEMUX_PIPELINE_ZERO_EN
        hold = 8'h00;
`else
        hold = 8'h12;
`endif
        b_valid = 1'b0; b_sel = 3'd1; b_in = 8'hFF;
        for (int t = 0; t < 3; t++) begin
            tick();
            n_cmp++;
            if (b_ov !== 6'b0 || b_out[8 +: 8] !== hold) begin
                n_bad++;
                $display("[TB] FAIL idle_ignore t=%0d: ov=%b lane1=%h, want 0/%h",
                         t, b_ov, b_out[8 +: 8], hold);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic exp_err;
        for (int t = 0; t < 7; t++) begin
            if (t == 0 || t == 3) begin
                b_valid = 1'b1; b_sel = (t == 0) ? 3'd7 : 3'd6; b_in = 8'h77;
            end else begin
                b_valid = 1'b0; b_sel = '0; b_in = '0;
            end
            tick();
            exp_err = (t == 1 || t == 4);
            n_cmp++;
            if (b_err !== exp_err || b_ov !== 6'b0) begin
                n_bad++;
                $display("[TB] FAIL out_of_range t=%0d: err=%b ov=%b, want %b/0",
                         t, b_err, b_ov, exp_err);
            end
        end
    endtask

    task automatic test_reset_flush();
        for (int t = 0; t < 3; t++) begin
            c_valid = 1'b1;
            c_sel   = (t == 0) ? 4'd5 : (t == 1) ? 4'd9 : 4'd15;
            c_in    = 8'(8'h31 + t);
            rst     = (t == 2);
            tick();
        end
        rst = 1'b0;
        c_valid = 1'b0; c_sel = '0; c_in = '0;
        n_cmp++;
        if (c_ov !== 16'h0 || c_out !== 128'h0) begin
            n_bad++;
            $display("[TB] FAIL flush_edge: ov=%h out=%h, want 0/0", c_ov, c_out);
        end
        for (int t = 0; t < 8; t++) begin
            tick();
            n_cmp++;
            if (c_ov !== 16'h0 || c_out !== 128'h0 || c_err !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL flush t=%0d: ov=%h err=%b out=%h, want all zero",
                         t, c_ov, c_err, c_out);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        test_reset();
        test_single();
        test_same_lane();
        test_back_to_back();
        test_idle_ignore();
        test_out_of_range();
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
